bitwise_logic_unit_64bit: RTL and testbench



---
 rtl/bitwise_logic_unit_64bit.sv | 115 +++++++++++
 tb/tb_bitwise_logic_unit_64bit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit_64bit.sv
// Two-stage bitwise logic unit: operand register feeding a result register, valid/ready on both sides.
// Define BLU_PARITY_EN to add a registered parity output alongside Out.
module bitwise_logic_unit_64bit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
`ifdef BLU_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_free;
  logic             s1_free;
  logic             accept;
  logic [WIDTH-1:0] result;

  // Stage 2 frees up when empty or being drained; stage 1 can then always move forward.
  assign s2_free  = !out_valid || out_ready;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = s1_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    result = '0;
    case (s1_op)
      OP_AND:  result = s1_a & s1_b;
      OP_OR:   result = s1_a | s1_b;
      OP_XOR:  result = s1_a ^ s1_b;
      OP_XNOR: result = ~(s1_a ^ s1_b);
      OP_NAND: result = ~(s1_a & s1_b);
      OP_NOR:  result = ~(s1_a | s1_b);
      OP_NOTA: result = ~s1_a;
      OP_PASS: result = s1_a;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= A;
      s1_b     <= B;
      s1_op    <= op;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Out/zero only load when a new result arrives, so they hold through stalls and after draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Out       <= '0;
      zero      <= 1'b0;
    end else if (s2_free) begin
      if (s1_valid) begin
        out_valid <= 1'b1;
        Out       <= result;
        zero      <= (result == '0);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BLU_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (s2_free && s1_valid) begin
      parity <= ^result;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit_64bit.sv
// Scoreboard bench for bitwise_logic_unit_64bit: driver pushes expected results, a negedge monitor pops and compares.
module tb_bitwise_logic_unit_64bit;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Out;
  logic          zero;
  logic [CW-1:0] op_count;
`ifdef BLU_PARITY_EN
  logic          parity;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         par;
  } exp_t;

  exp_t          expQ[$];
  int            checks = 0;
  int            fails  = 0;
  logic [CW-1:0] modelCount;

  bitwise_logic_unit_64bit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out(Out),
    .zero(zero),
    .op_count(op_count)
`ifdef BLU_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] o, input logic [W-1:0] expRes);
    int   waited;
    exp_t e;
    waited   = 0;
    A        = a;
    B        = b;
    op       = o;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: actual=in_ready low for %0d cycles required=accept", waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.res = expRes;
    e.z   = (expRes == '0);
    e.par = ^expRes;
    expQ.push_back(e);
    modelCount++;
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake and checks that stalled outputs stay frozen.
  logic         prevStall = 1'b0;
  logic [W-1:0] heldOut;
  logic         heldZero;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_out", Out, heldOut);
        checkOutput("hold_zero", 64'(zero), 64'(heldZero));
      end
      prevStall = out_valid && !out_ready;
      heldOut   = Out;
      heldZero  = zero;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_result: actual=%h required=no output", Out);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", Out, e.res);
          checkOutput("zero", 64'(zero), 64'(e.z));
`ifdef BLU_PARITY_EN
          checkOutput("parity", 64'(parity), 64'(e.par));
`endif
        end
      end
    end
  end

  initial begin
    int waited;
    rst        = 1'b1;
    in_valid   = 1'b0;
    A          = '0;
    B          = '0;
    op         = '0;
    out_ready  = 1'b1;
    modelCount = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out", Out, 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_count", 64'(op_count), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    idle(1);

    // Reset pulse while one op is in flight, then XNOR with latency check
    applyStimulus(64'h5555_5555_5555_5555, 64'h0, 3'b111, 64'h5555_5555_5555_5555);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    expQ.delete();
    modelCount = '0;
    #1;
    checkOutput("pulse_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 3'b011, 64'h4444_6666_0000_6666);
    in_valid = 1'b0;
    checkOutput("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 64'(out_valid), 64'd1);
    checkOutput("xnor_out", Out, 64'h4444_6666_0000_6666);
    checkOutput("count_one", 64'(op_count), 64'd1);
    idle(2);

    // Back-to-back stream
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 3'b011, 64'h0000_0000_0000_0001);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111, 3'b011, 64'h1111_1111_1111_1111);
    in_valid = 1'b0;
    checkOutput("b2b_first", Out, 64'h0000_0000_0000_0001);
    @(posedge clk);
    #1;
    checkOutput("b2b_second", Out, 64'h1111_1111_1111_1111);
    idle(2);

    // Zero flag
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b000, 64'h0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_0000_0000_5678, 3'b110, 64'h0);
    idle(2);
    checkOutput("zero_flag", 64'(zero), 64'd1);
    idle(1);

    // Backpressure: third op must wait until the consumer drains
    out_ready = 1'b0;
    applyStimulus(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_0000_0000, 3'b001, 64'hFFFF_FFFF_0F0F_0F0F);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 3'b100, 64'hFFFF_FFFF_0000_0000);
    A        = 64'h0;
    B        = 64'h0;
    op       = 3'b101;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out", Out, 64'hFFFF_FFFF_0F0F_0F0F);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus(64'h0, 64'h0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0, 3'b111, 64'h1234_5678_9ABC_DEF0);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b010, 64'h0);
    idle(4);
    checkOutput("count_model", 64'(op_count), 64'(modelCount));

    // Reset with two ops in flight
    out_ready = 1'b0;
    applyStimulus(64'hDEAD_BEEF_0000_0000, 64'h0, 3'b111, 64'hDEAD_BEEF_0000_0000);
    applyStimulus(64'hCAFE_F00D_0000_0000, 64'h0, 3'b111, 64'hCAFE_F00D_0000_0000);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    expQ.delete();
    modelCount = '0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out", Out, 64'd0);
    checkOutput("mid_rst_count", 64'(op_count), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    checkOutput("no_stale", 64'(out_valid), 64'd0);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      applyStimulus(64'(i + 1), 64'h0, 3'b111, 64'(i + 1));
    end
    in_valid = 1'b0;
    checkOutput("wrap_count", 64'(op_count), 64'd1);

    waited = 0;
    while (expQ.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (expQ.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: actual=%0d results outstanding required=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
